pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 8: width of the cycle accumulators and result outputs.
REQ-002 Parameter SYNC_STAGES, default 2: number of input synchronizer flops.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 pwm_in  input  1: asynchronous PWM waveform, typically the output of the PWM generator stage.
REQ-006 meas_en  input  1: high enables measurement; low forces IDLE.
REQ-007 high_cnt  output  CNT_W: clk cycles the synchronized input was high in the last measured period.
REQ-008 period_cnt  output  CNT_W: clk cycles between the last two synchronized rising edges.
REQ-009 meas_valid  output  1: one-cycle pulse when high_cnt, period_cnt and no_signal update.
REQ-010 no_signal  output  1: level; set when a published result came from a timeout, cleared when a result is published from an edge.

Function
REQ-011 pwm_in SHALL pass through SYNC_STAGES flops; a rising edge is sync_q=1 with prev_q=0, detected SYNC_STAGES+1 cycles after the pwm_in transition.
REQ-012 The FSM SHALL have exactly three states: IDLE, ARM, MEAS.
REQ-013 IDLE: accumulators held at 0; go to ARM when meas_en=1.
REQ-014 ARM: wait for a rising edge; on that edge go to MEAS, set period_acc=1, set high_acc=1, publish nothing.
REQ-015 MEAS, per cycle without an edge: period_acc+1; high_acc+1 if sync_q=1.
REQ-016 MEAS, on an edge: publish high_cnt=high_acc and period_cnt=period_acc, clear no_signal, pulse meas_valid next cycle, restart both accumulators at 1, stay in MEAS.
REQ-017 Timeout: in MEAS with period_acc=2^CNT_W-1 and no edge this cycle, publish period_cnt=0, set high_cnt to all-ones if sync_q=1 else 0, set no_signal=1, pulse meas_valid, go to ARM.
REQ-018 An edge in the same cycle as the timeout condition SHALL win; a normal result with period_cnt=2^CNT_W-1 is published.
REQ-019 ARM SHALL also time out after 2^CNT_W-1 cycles without an edge, publishing as in REQ-017 and staying in ARM; its wait counter restarts on entry to ARM.
REQ-020 meas_en=0 in any state SHALL move the FSM to IDLE next cycle, clear the accumulators, suppress meas_valid, and hold the published outputs.
REQ-021 The accumulators SHALL never wrap; REQ-017 and REQ-019 bound them.
REQ-022 Outputs SHALL be registered; there is no combinational path from pwm_in to any output.

Reset
REQ-023 With rst=1 at a clock edge: state=IDLE, synchronizer and prev_q=0, accumulators=0, high_cnt=0, period_cnt=0, meas_valid=0, no_signal=0.
REQ-024 rst SHALL override meas_en and any in-progress measurement; after rst drops, a first edge only arms (REQ-014).

Structure
REQ-025 Shared package pwm_pkg SHALL hold CNT_W default, SYNC_STAGES default, and the state encoding IDLE=2'd0, ARM=2'd1, MEAS=2'd2.
REQ-026 One sub-module, pwm_sync_edge, SHALL contain the synchronizer chain and the rising-edge detector, and output sync_q and rise.

Verification
REQ-027 Assert rst 3 cycles with pwm_in toggling -> all outputs 0, no meas_valid.
REQ-028 meas_en=1, pwm_in repeating high 3 / low 5 cycles -> no result on the first edge, then meas_valid every 8 cycles with high_cnt=3, period_cnt=8, no_signal=0.
REQ-029 pwm_in high 100 / low 155 -> high_cnt=100, period_cnt=255, no_signal=0 (edge wins at the boundary).
REQ-030 One edge, then pwm_in held high 300 cycles -> meas_valid 255 cycles after the edge with period_cnt=0, high_cnt=255, no_signal=1; with pwm_in held low instead, high_cnt=0.
REQ-031 Drop meas_en mid-period, then re-enable -> no meas_valid, prior outputs held; after re-enable the first edge only arms and the second edge publishes.
REQ-032 Assert rst mid-MEAS -> outputs 0 next cycle, and the next result requires two fresh edges.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture slice: default widths and the
// measurement FSM state encoding.
package pwm_pkg;

   localparam int CNT_W_DEF       = 8;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } meas_state_e;

   // Result reported for a timeout: all-ones if the line is stuck high, zero otherwise.
   function automatic logic [CNT_W_DEF-1:0] stuck_level(input logic level_s);
      return {CNT_W_DEF{level_s}};
   endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Input synchronizer chain for the asynchronous PWM line plus a rising-edge
// detector on the synchronized level.
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic sync_q,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain_r;
   logic                   prev_r;

   // Synchronizer shift chain and one-cycle history of its output.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_r <= {SYNC_STAGES{1'b0}};
         prev_r  <= 1'b0;
      end else begin
         chain_r[0] <= pwm_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            chain_r[i] <= chain_r[i-1];
         end
         prev_r <= chain_r[SYNC_STAGES-1];
      end
   end

   assign sync_q = chain_r[SYNC_STAGES-1];
   assign rise   = chain_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in clk cycles, with a
// timeout that flags a missing or stuck signal.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   input  logic             meas_en,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             no_signal
);

   localparam logic [CNT_W-1:0] ACC_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ACC_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ACC_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ARM_LIMIT = ACC_MAX - ACC_ONE;

   logic             sync_s;
   logic             rise_s;
   meas_state_e      state_r;
   logic [CNT_W-1:0] period_acc_r;
   logic [CNT_W-1:0] high_acc_r;

   pwm_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk   (clk),
      .rst   (rst),
      .pwm_in(pwm_in),
      .sync_q(sync_s),
      .rise  (rise_s)
   );

   // Measurement FSM; in ARM the period accumulator doubles as the wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         period_acc_r <= ACC_ZERO;
         high_acc_r   <= ACC_ZERO;
         high_cnt     <= ACC_ZERO;
         period_cnt   <= ACC_ZERO;
         meas_valid   <= 1'b0;
         no_signal    <= 1'b0;
      end else if (!meas_en) begin
         state_r      <= IDLE;
         period_acc_r <= ACC_ZERO;
         high_acc_r   <= ACC_ZERO;
         meas_valid   <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               state_r      <= ARM;
               period_acc_r <= ACC_ZERO;
               high_acc_r   <= ACC_ZERO;
            end
            ARM: begin
               if (rise_s) begin
                  state_r      <= MEAS;
                  period_acc_r <= ACC_ONE;
                  high_acc_r   <= ACC_ONE;
               end else if (period_acc_r == ARM_LIMIT) begin
                  high_cnt     <= {CNT_W{sync_s}};
                  period_cnt   <= ACC_ZERO;
                  no_signal    <= 1'b1;
                  meas_valid   <= 1'b1;
                  period_acc_r <= ACC_ZERO;
               end else begin
                  period_acc_r <= period_acc_r + ACC_ONE;
               end
            end
            MEAS: begin
               // An edge on the last countable cycle still yields a full-scale result.
               if (rise_s) begin
                  high_cnt     <= high_acc_r;
                  period_cnt   <= period_acc_r;
                  no_signal    <= 1'b0;
                  meas_valid   <= 1'b1;
                  period_acc_r <= ACC_ONE;
                  high_acc_r   <= ACC_ONE;
               end else if (period_acc_r == ACC_MAX) begin
                  high_cnt     <= {CNT_W{sync_s}};
                  period_cnt   <= ACC_ZERO;
                  no_signal    <= 1'b1;
                  meas_valid   <= 1'b1;
                  state_r      <= ARM;
                  period_acc_r <= ACC_ZERO;
                  high_acc_r   <= ACC_ZERO;
               end else begin
                  period_acc_r <= period_acc_r + ACC_ONE;
                  high_acc_r   <= high_acc_r + {{(CNT_W-1){1'b0}}, sync_s};
               end
            end
            default: begin
               state_r      <= IDLE;
               period_acc_r <= ACC_ZERO;
               high_acc_r   <= ACC_ZERO;
            end
         endcase
      end
   end

endmodule
